fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Front-end sequencer for the 8-bit nRisc pipeline. Owns the program counter and
//  issues one instruction word per cycle to the decode controller. Handles the
//  two-word LI (second word = immediate), stalls on fetched JMP until execute
//  resolves it, redirects the PC and inserts flush bubbles.
// PARAMETERS
//  PC_WIDTH      8       program counter / instruction address width
//  RESET_PC      8'h00   PC value loaded on reset
//  FLUSH_CYCLES  2       bubbles after a redirect (>=1)
//  OP_LI         3'b011  opcode of two-word load-immediate
//  OP_JMP        3'b111  opcode of jump
// PORTS
//  clock         in   1         system clock, rising edge
//  reset         in   1         synchronous, active-high
//  stall         in   1         downstream hold request
//  instr_in      in   8         imem word at pc (combinational read, same cycle)
//  jump_taken    in   1         execute resolved a jump this cycle
//  jump_target   in   PC_WIDTH  redirect address, valid with jump_taken
//  pc            out  PC_WIDTH  current fetch address
//  instr_out     out  8         issued word (opcode = instr_out[7:5])
//  instr_valid   out  1         instr_out is an instruction
//  imm_valid     out  1         instr_out is an LI immediate word
//  jumped        out  1         one-cycle redirect acknowledge to decode
// BEHAVIOUR
//  - All outputs registered; one cycle from instr_in sample to instr_out.
//  - Reset: pc=RESET_PC, instr_out=0, instr_valid=0, imm_valid=0, jumped=0,
//    flush count=0, state=FETCH. Reset wins over all inputs, any state.
//  - States: FETCH, IMM, JWAIT, FLUSH.
//  - FETCH, stall=0: instr_out<=instr_in, instr_valid<=1, imm_valid<=0, pc<=pc+1.
//    opcode==OP_LI -> IMM; opcode==OP_JMP -> JWAIT; else stay FETCH.
//  - IMM, stall=0: instr_out<=instr_in, imm_valid<=1, instr_valid<=0, pc<=pc+1 -> FETCH.
//  - FETCH/IMM, stall=1: pc, state, instr_out, instr_valid, imm_valid all hold.
//  - JWAIT: pc holds; instr_valid=imm_valid=0; stays until jump_taken; stall ignored.
//  - FLUSH: instr_valid=imm_valid=0, pc holds; count decrements each cycle;
//    count==0 -> FETCH; stall ignored.
//  - jump_taken=1 (any state, priority over stall and fetch): pc<=jump_target,
//    instr_valid<=0, imm_valid<=0, count<=FLUSH_CYCLES-1, jumped<=1, state<=FLUSH.
//    Word at instr_in that cycle discarded (incl. LI immediate, JMP).
//  - jumped high exactly one cycle after each sampled jump_taken, else 0.
//  - jump_taken during FLUSH restarts flush with new target.
//  - PC arithmetic modulo 2^PC_WIDTH: 8'hFF+1 -> 8'h00, no flag.
//  - LI straddling wrap: opcode at 8'hFF, immediate fetched from 8'h00.
// TESTING
//  1 reset, imem[0..2]=ADD,SUB,ADD, stall=0 -> pc 0,1,2,3; instr_valid=1 from
//    cycle 1; instr_out follows imem one cycle later.
//  2 imem[4]=8'h6A (LI), imem[5]=8'h5C -> cycle N instr_valid=1 out=6A;
//    N+1 imm_valid=1 instr_valid=0 out=5C; pc=6.
//  3 imem[7]=8'hE0 (JMP), jump_taken 3 cycles later, target=8'h20 -> bubbles in
//    JWAIT; jumped=1 one cycle; 2 bubbles; next issued word from 8'h20.
//  4 stall=1 for 3 cycles mid-LI (in IMM) -> pc, instr_out, imm_valid frozen;
//    on release immediate issued once, no duplicate.
//  5 jump_taken with stall=1 in FETCH, target=8'h40 -> redirect taken, stall ignored.
//  6 pc=8'hFF, imem[FF]=LI, imem[00]=8'h11; reset asserted in FLUSH ->
//    wrap to 00 with imm 11; reset returns all outputs to reset values next edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer for the 8-bit nRisc pipeline: owns the PC, issues one
// word per cycle, sequences two-word LI, parks on JMP and flushes after a redirect.
module fetch_sequencer #(
  parameter int                    PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
  parameter int                    FLUSH_CYCLES = 2,
  parameter logic [2:0]            OP_LI        = 3'b011,
  parameter logic [2:0]            OP_JMP       = 3'b111
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic [7:0]          instr_in,
  input  logic                jump_taken,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [7:0]          instr_out,
  output logic                instr_valid,
  output logic                imm_valid,
  output logic                jumped,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_IMM   = 2'd1,
    S_JWAIT = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          instr_out_q, instr_out_d;
  logic                instr_valid_q, instr_valid_d;
  logic                imm_valid_q, imm_valid_d;
  logic                jumped_q, jumped_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          opcode;

  assign opcode = instr_in[7:5];

  // Handshake: stall is the inverted downstream ready. While stall=1 in FETCH/IMM
  // the issued word and its valid flags are held, so decode sees the same beat
  // until it accepts; JWAIT/FLUSH emit bubbles and never wait on stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = instr_valid_q;
    imm_valid_d   = imm_valid_q;
    cnt_d         = cnt_q;
    jumped_d      = 1'b0;

    if (jump_taken) begin
      // A resolved jump overrides everything; the word on instr_in is dropped.
      pc_d          = jump_target;
      instr_valid_d = 1'b0;
      imm_valid_d   = 1'b0;
      cnt_d         = FLUSH_LOAD;
      jumped_d      = 1'b1;
      state_d       = S_FLUSH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!stall) begin
            instr_out_d   = instr_in;
            instr_valid_d = 1'b1;
            imm_valid_d   = 1'b0;
            pc_d          = pc_q + PC_WIDTH'(1);
            if (opcode == OP_LI) begin
              state_d = S_IMM;
            end else if (opcode == OP_JMP) begin
              state_d = S_JWAIT;
            end
          end
        end
        S_IMM: begin
          if (!stall) begin
            instr_out_d   = instr_in;
            instr_valid_d = 1'b0;
            imm_valid_d   = 1'b1;
            pc_d          = pc_q + PC_WIDTH'(1);
            state_d       = S_FETCH;
          end
        end
        S_JWAIT: begin
          instr_valid_d = 1'b0;
          imm_valid_d   = 1'b0;
        end
        S_FLUSH: begin
          instr_valid_d = 1'b0;
          imm_valid_d   = 1'b0;
          if (cnt_q == '0) begin
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_out_q   <= 8'h00;
      instr_valid_q <= 1'b0;
      imm_valid_q   <= 1'b0;
      jumped_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
      imm_valid_q   <= imm_valid_d;
      jumped_q      <= jumped_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign imm_valid   = imm_valid_q;
  assign jumped      = jumped_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-cycle expected outputs queued with
// the stimulus and compared one cycle after each driven edge.
module tb_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic [7:0] instr_in;
  logic       jump_taken = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic [7:0] pc;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       imm_valid;
  logic       jumped;
  logic [1:0] dbg_state;

  logic [7:0]  imem [0:255];
  logic [10:0] stim_q[$];
  logic [18:0] exp_q[$];
  logic [10:0] s;
  logic [18:0] e;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign instr_in = imem[pc];

  fetch_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .instr_in    (instr_in),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .pc          (pc),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .imm_valid   (imm_valid),
    .jumped      (jumped),
    .dbg_state   (dbg_state)
  );

  // stimulus word: {reset, stall, jump_taken, jump_target}
  function automatic logic [10:0] st(input logic r, input logic sl, input logic j,
                                     input logic [7:0] t);
    return {r, sl, j, t};
  endfunction

  // expected word: {instr_valid, imm_valid, jumped, instr_out, pc}
  function automatic logic [18:0] ex(input logic v, input logic i, input logic j,
                                     input logic [7:0] o, input logic [7:0] p);
    return {v, i, j, o, p};
  endfunction

  task automatic cycle(input logic [10:0] w);
    {reset, stall, jump_taken, jump_target} = w;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cycle(st(1, 1, 1, 8'h55));
    cycle(st(1, 0, 0, 8'h00));
    n_checks++;
    if ({instr_valid, imm_valid, jumped, instr_out, pc, dbg_state} !== {3'b000, 8'h00, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b imm=%b j=%b out=%h pc=%h st=%0d, expected all zero",
               instr_valid, imm_valid, jumped, instr_out, pc, dbg_state);
    end
  endtask

  task automatic test_sequential();
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h20, 8'h01));
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h41, 8'h02));
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h22, 8'h03));
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h23, 8'h04));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL sequential: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_li();
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h6A, 8'h05));
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(0, 1, 0, 8'h5C, 8'h06));
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h24, 8'h07));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL li: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_jmp_wait();
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(1, 0, 0, 8'hE0, 8'h08));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h08));
    stim_q.push_back(st(0, 1, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h08));
    stim_q.push_back(st(0, 0, 1, 8'h20)); exp_q.push_back(ex(0, 0, 1, 8'h00, 8'h20));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h20));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h20));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(1, 0, 0, 8'h33, 8'h21));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL jmp_wait: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_stall_imm();
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h6B, 8'h22));
    for (int i = 0; i < 3; i++) begin
      stim_q.push_back(st(0, 1, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h6B, 8'h22));
    end
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(0, 1, 0, 8'h77, 8'h23));
    stim_q.push_back(st(0, 0, 0, 0)); exp_q.push_back(ex(1, 0, 0, 8'h26, 8'h24));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL stall_imm: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_jump_over_stall();
    stim_q.push_back(st(0, 1, 1, 8'h40)); exp_q.push_back(ex(0, 0, 1, 8'h00, 8'h40));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h40));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h40));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(1, 0, 0, 8'h35, 8'h41));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL jump_over_stall: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_flush_restart();
    stim_q.push_back(st(0, 0, 1, 8'h50)); exp_q.push_back(ex(0, 0, 1, 8'h00, 8'h50));
    stim_q.push_back(st(0, 1, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h50));
    stim_q.push_back(st(0, 0, 1, 8'h60)); exp_q.push_back(ex(0, 0, 1, 8'h00, 8'h60));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h60));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h60));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(1, 0, 0, 8'h36, 8'h61));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL flush_restart: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_jump_in_imm();
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(1, 0, 0, 8'h6D, 8'h62));
    stim_q.push_back(st(0, 0, 1, 8'h70)); exp_q.push_back(ex(0, 0, 1, 8'h00, 8'h70));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h70));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'h70));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(1, 0, 0, 8'h37, 8'h71));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL jump_in_imm: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    imem[8'h00] = 8'h11;
    stim_q.push_back(st(0, 0, 1, 8'hFF)); exp_q.push_back(ex(0, 0, 1, 8'h00, 8'hFF));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'hFF));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 0, 0, 8'h00, 8'hFF));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(1, 0, 0, 8'h6C, 8'h00));
    stim_q.push_back(st(0, 0, 0, 0));     exp_q.push_back(ex(0, 1, 0, 8'h11, 8'h01));
    stim_q.push_back(st(0, 0, 1, 8'h80)); exp_q.push_back(ex(0, 0, 1, 8'h00, 8'h80));
    while (stim_q.size() > 0) begin
      cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      n_checks++;
      if ({instr_valid, imm_valid, jumped, pc} !== {e[18:16], e[7:0]} ||
          ((e[18] | e[17]) && instr_out !== e[15:8])) begin
        n_fail++;
        $display("FAIL wrap: got v=%b imm=%b j=%b out=%h pc=%h, expected v=%b imm=%b j=%b out=%h pc=%h",
                 instr_valid, imm_valid, jumped, instr_out, pc, e[18], e[17], e[16], e[15:8], e[7:0]);
      end
    end
    // reset in FLUSH, with a competing jump, must still return everything to reset values
    cycle(st(1, 0, 1, 8'h90));
    n_checks++;
    if ({instr_valid, imm_valid, jumped, instr_out, pc, dbg_state} !== {3'b000, 8'h00, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_in_flush: got v=%b imm=%b j=%b out=%h pc=%h st=%0d, expected all zero",
               instr_valid, imm_valid, jumped, instr_out, pc, dbg_state);
    end
    cycle(st(0, 0, 0, 0));
    n_checks++;
    if ({instr_valid, imm_valid, jumped, instr_out, pc} !== {3'b100, 8'h11, 8'h01}) begin
      n_fail++;
      $display("FAIL after_reset: got v=%b imm=%b j=%b out=%h pc=%h, expected v=1 imm=0 j=0 out=11 pc=01",
               instr_valid, imm_valid, jumped, instr_out, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'h2F;
    imem[8'h00] = 8'h20; imem[8'h01] = 8'h41; imem[8'h02] = 8'h22; imem[8'h03] = 8'h23;
    imem[8'h04] = 8'h6A; imem[8'h05] = 8'h5C; imem[8'h06] = 8'h24; imem[8'h07] = 8'hE0;
    imem[8'h20] = 8'h33; imem[8'h21] = 8'h6B; imem[8'h22] = 8'h77; imem[8'h23] = 8'h26;
    imem[8'h24] = 8'h27; imem[8'h40] = 8'h35; imem[8'h60] = 8'h36; imem[8'h61] = 8'h6D;
    imem[8'h62] = 8'h78; imem[8'h70] = 8'h37; imem[8'hFF] = 8'h6C;
    s = '0;
    e = '0;

    test_reset();
    test_sequential();
    test_li();
    test_jmp_wait();
    test_stall_imm();
    test_jump_over_stall();
    test_flush_restart();
    test_jump_in_imm();
    test_wrap_and_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
